// File: rtl/atx_sequencer.sv
// UART transmit sequencer: byte FIFO feeding the transmitter load/busy handshake,
// with an acknowledge watchdog that drops a byte the transmitter never accepts.
module atx_sequencer #(
  parameter int unsigned DEPTH_LOG2  = 2,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            atx_data,
  output logic                  atx_load,
  input  logic                  atx_busy,
  output logic                  timeout_err,
  input  logic                  clr_err
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [15:0] TimerLast = 16'(ACK_TIMEOUT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  busy_meta_q, busy_s_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, empty_q;
  logic [7:0]            mem [Depth];
  logic [7:0]            data_q;
  logic                  load_q, load_d;
  logic [15:0]           timer_q, timer_d;
  logic                  err_q, err_set;
  logic                  push, pop;

  // Push is judged against the pre-pop occupancy, so a full FIFO drops it.
  assign push = wr_en && (count_q != DepthCount);
  assign pop  = (state_q == StIdle) && !empty_q && !busy_s_q;

  assign full        = full_q;
  assign empty       = empty_q;
  assign count       = count_q;
  assign atx_data    = data_q;
  assign atx_load    = load_q;
  assign timeout_err = err_q;

  // Two-flop synchronizer for the transmitter busy line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      busy_meta_q <= atx_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Handshake FSM next-state: load, wait for ack or timeout, then wait for idle.
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    timer_d = timer_q;
    err_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (pop) begin
          load_d  = 1'b1;
          timer_d = 16'd0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (busy_s_q) begin
          load_d  = 1'b0;
          state_d = StDrain;
        end else if (timer_q == TimerLast) begin
          load_d  = 1'b0;
          err_set = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StDrain: begin
        load_d = 1'b0;
        if (!busy_s_q) state_d = StIdle;
      end
      default: begin
        load_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // FIFO pointers, flags, FSM, output and error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      data_q   <= 8'h00;
      load_q   <= 1'b0;
      timer_q  <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      timer_q <= timer_d;
      count_q <= count_d;
      full_q  <= (count_d == DepthCount);
      empty_q <= (count_d == '0);
      if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        data_q   <= mem[rd_ptr_q];
      end
      // Set takes priority over clear.
      if (err_set) err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;
    end
  end

endmodule
